// File: rtl/icache_pkg.sv
// Shared types and geometry for the direct-mapped instruction cache.
package icache_pkg;

    // Controller states; COMPARE is the idle/lookup state entered from reset.
    typedef enum logic [1:0] {
        COMPARE  = 2'd0,
        ALLOCATE = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    localparam int ADDR_W      = 30;   // core word address width
    localparam int LINE_ADDR_W = 28;   // memory line address width
    localparam int WORD_W      = 32;
    localparam int LINE_W      = 128;  // four words per line, one memory beat
    localparam int OFFSET_W    = 2;    // word-within-line select

    // Index bits needed for a given number of lines (NUM_BLOCKS >= 2).
    function automatic int index_w(input int num_blocks);
        return $clog2(num_blocks);
    endfunction

    // Whatever is left of the word address above offset and index is tag.
    function automatic int tag_w(input int num_blocks);
        return ADDR_W - OFFSET_W - index_w(num_blocks);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Core-side fetch port and memory-side fill port of the instruction cache.
// slave  : the cache itself.
// master : the environment (core + instruction memory) around the cache.
interface icache_if;
    logic                             proc_read;
    logic [icache_pkg::ADDR_W-1:0]      proc_addr;
    logic [icache_pkg::WORD_W-1:0]      proc_rdata;
    logic                             proc_stall;
    logic                             mem_read;
    logic [icache_pkg::LINE_ADDR_W-1:0] mem_addr;
    logic [icache_pkg::LINE_W-1:0]      mem_rdata;
    logic                             mem_ready;

    modport slave (
        input  proc_read, proc_addr, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_addr
    );

    modport master (
        output proc_read, proc_addr, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_addr
    );
endinterface

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one combinational read port (zero-cycle hits),
// one synchronous write port. Only the valid bits are reset.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int INDEX_W    = 3,
    parameter int TAG_W      = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_data
);

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] valid_d;
    logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
    logic [LINE_W-1:0]     data_mem [NUM_BLOCKS];

    // A fill marks its line valid; nothing ever clears a line except reset.
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    // Valid bits clear asynchronously so the first fetch after reset misses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data payload is meaningless while invalid, so it is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with single-beat line fills.
module icache
    import icache_pkg::*;
#(
    parameter int NUM_BLOCKS      = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    icache_if.slave  bus
);

    localparam int INDEX_W = index_w(NUM_BLOCKS);
    localparam int TAG_W   = tag_w(NUM_BLOCKS);
    localparam int SEL_W   = $clog2(WORDS_PER_BLOCK);

    state_t                 state_q, state_d;
    logic                   mem_read_q, mem_read_d;
    logic [LINE_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]      fill_q, fill_d;

    logic [SEL_W-1:0]   offset;
    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               line_valid;
    logic [TAG_W-1:0]   line_tag;
    logic [LINE_W-1:0]  line_data;
    logic               hit;
    logic               wr_en;

    assign offset = bus.proc_addr[OFFSET_W-1:0];
    assign index  = bus.proc_addr[OFFSET_W +: INDEX_W];
    assign tag    = bus.proc_addr[ADDR_W-1 -: TAG_W];

    // The fill target comes from the latched miss address, never from
    // proc_addr, so the write is immune to what the core drives meanwhile.
    icache_line_array #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .INDEX_W    (INDEX_W),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_index (mem_addr_q[INDEX_W-1:0]),
        .wr_tag   (mem_addr_q[LINE_ADDR_W-1 -: TAG_W]),
        .wr_data  (fill_q)
    );

    assign hit = line_valid && (line_tag == tag);

    // Next-state and next-output decisions for the fill controller.
    always_comb begin
        state_d    = state_q;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
        fill_d     = fill_q;
        wr_en      = 1'b0;
        case (state_q)
            COMPARE: begin
                if (bus.proc_read && !hit) begin
                    state_d    = ALLOCATE;
                    mem_read_d = 1'b1;
                    mem_addr_d = bus.proc_addr[ADDR_W-1:OFFSET_W];
                end
            end
            ALLOCATE: begin
                if (bus.mem_ready) begin
                    state_d    = UPDATE;
                    mem_read_d = 1'b0;
                    fill_d     = bus.mem_rdata;
                end
            end
            UPDATE: begin
                wr_en   = 1'b1;
                state_d = COMPARE;
            end
            default: begin
                state_d    = COMPARE;
                mem_read_d = 1'b0;
            end
        endcase
    end

    // Controller state plus registered memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COMPARE;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
            fill_q     <= fill_d;
        end
    end

    // Core-side outputs are combinational for zero-cycle hits; both are
    // forced low while reset is asserted.
    assign bus.proc_stall = rst_n && ((state_q != COMPARE) || (bus.proc_read && !hit));
    assign bus.proc_rdata = rst_n ? line_data[WORD_W*offset +: WORD_W] : '0;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_addr   = mem_addr_q;

endmodule
